// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator sweep checker: FSM states, default
// sizing and the reference flag function.
package cmp_pkg;

    localparam int unsigned CMP_WIDTH_DEF = 8;
    localparam int unsigned CMP_LAT_DEF   = 0;
    localparam int unsigned CMP_ECW_DEF   = 16;
    // Widest operand the reference function accepts.
    localparam int unsigned CMP_MAX_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Expected flag vector {gt, eq, lt} for an unsigned compare.
    function automatic logic [2:0] cmp_expect(input logic [CMP_MAX_W-1:0] a,
                                              input logic [CMP_MAX_W-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

endpackage

// File: rtl/cmp_ref_model.sv
// Combinational reference magnitude comparator, reusable outside the checker.
import cmp_pkg::*;

module cmp_ref_model #(
    parameter int unsigned WIDTH = CMP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       flags_c
);

    // Zero-extend operands into the shared reference function.
    always_comb begin
        flags_c = cmp_expect(CMP_MAX_W'(a), CMP_MAX_W'(b));
    end

endmodule

// File: rtl/cmp_sweep_checker.sv
// On-board self-test for a three-output magnitude comparator: sweeps all
// (A,B) pairs, samples the flags LAT cycles after each pair is presented and
// reports error count, first failing pair and pass/done.
// Optional build macro CMP_STOP_ON_ERR_EN: stop the sweep at the first
// mismatch, holding the failing pair on A/B.
import cmp_pkg::*;

module cmp_sweep_checker #(
    parameter int unsigned WIDTH = CMP_WIDTH_DEF,
    parameter int unsigned LAT   = CMP_LAT_DEF,
    parameter int unsigned ECW   = CMP_ECW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             A_greater_B,
    input  logic             A_equal_B,
    input  logic             A_less_B,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ECW-1:0]   err_count,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b
);

    localparam int unsigned WCW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [WIDTH-1:0] OP_MAX  = '1;
    localparam logic [ECW-1:0]   ERR_MAX = '1;

    state_t           state;
    logic [WCW-1:0]   wcnt;
    logic [2:0]       exp_flags_c;
    logic [2:0]       got_flags_c;
    logic             sample_c;
    logic             mismatch_c;
    logic             last_c;
    logic             stop_c;
    logic [ECW-1:0]   err_next_c;

    cmp_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a       (A),
        .b       (B),
        .flags_c (exp_flags_c)
    );

    // Sample decision, mismatch detection and saturating error increment.
    always_comb begin
        got_flags_c = {A_greater_B, A_equal_B, A_less_B};
        sample_c    = (state == ST_APPLY) && (wcnt == WCW'(LAT));
        mismatch_c  = sample_c && (got_flags_c != exp_flags_c);
        last_c      = (A == OP_MAX) && (B == OP_MAX);
        err_next_c  = err_count;
        if (mismatch_c && (err_count != ERR_MAX)) begin
            err_next_c = err_count + ECW'(1);
        end
`ifdef CMP_STOP_ON_ERR_EN
        stop_c = mismatch_c;
`else
        stop_c = 1'b0;
`endif
    end

    // Sweep FSM with registered operands, status and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wcnt        <= '0;
            A           <= '0;
            B           <= '0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_APPLY;
                        wcnt        <= '0;
                        A           <= '0;
                        B           <= '0;
                        err_count   <= '0;
                        first_err_a <= '0;
                        first_err_b <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (sample_c) begin
                        wcnt      <= '0;
                        err_count <= err_next_c;
                        if (mismatch_c && (err_count == '0)) begin
                            first_err_a <= A;
                            first_err_b <= B;
                        end
                        if (stop_c || last_c) begin
                            // Operands hold: all-ones at sweep end, failing pair on stop.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next_c == '0);
                        end else begin
                            B <= B + WIDTH'(1);
                            if (B == OP_MAX) begin
                                A <= A + WIDTH'(1);
                            end
                        end
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: a LAT=0 instance driven by a configurable
// (possibly faulty or pipelined) comparator, and a LAT=2 instance driven by a
// two-stage registered comparator.
module tb_cmp_sweep_checker;

`ifdef CMP_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int len;
        int err;
        int fa;
        int fb;
        int a_end;
        int b_end;
    } exp_t;

    typedef struct {
        int         mode;      // 0 good, 1 eq stuck 0, 2 single-pair fault, 3 pipelined
        int         fa;
        int         fb;
        logic [2:0] mask;
        bit         extra_starts;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start2 = 1'b0;

    logic [3:0]  a0, b0, fa0, fb0, a2, b2, fa2, fb2;
    logic        busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0] err0, err2;
    logic [2:0]  flags0, flags2;
    logic [2:0]  p0_1, p0_2, p2_1, p2_2;

    int         cur_mode = 0;
    int         cur_fa = 0;
    int         cur_fb = 0;
    logic [2:0] cur_mask = 3'b000;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] comp_flags(input int mode, input int fa, input int fb,
                                              input logic [2:0] mask, input int a, input int b);
        logic [2:0] f;
        f = {a > b, a == b, a < b};
        if (mode == 1) f[1] = 1'b0;
        if (mode == 2 && a == fa && b == fb) f = f ^ mask;
        return f;
    endfunction

    // Walk all pairs in sweep order, recording what the checker should report.
    function automatic exp_t model(input int mode, input int fa, input int fb, input logic [2:0] mask);
        exp_t e;
        e = '{len: 0, err: 0, fa: 0, fb: 0, a_end: 15, b_end: 15};
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e.len++;
                if (comp_flags(mode, fa, fb, mask, a, b) != {a > b, a == b, a < b}) begin
                    if (e.err == 0) begin
                        e.fa = a;
                        e.fb = b;
                    end
                    e.err++;
                    if (STOP) begin
                        e.a_end = a;
                        e.b_end = b;
                        return e;
                    end
                end
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        p0_1 <= {a0 > b0, a0 == b0, a0 < b0};
        p0_2 <= p0_1;
        p2_1 <= {a2 > b2, a2 == b2, a2 < b2};
        p2_2 <= p2_1;
    end

    always_comb begin
        flags0 = (cur_mode == 3) ? p0_2 : comp_flags(cur_mode, cur_fa, cur_fb, cur_mask, int'(a0), int'(b0));
        flags2 = p2_2;
    end

    cmp_sweep_checker #(.WIDTH(4), .LAT(0), .ECW(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0),
        .A_greater_B(flags0[2]), .A_equal_B(flags0[1]), .A_less_B(flags0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_a(fa0), .first_err_b(fb0)
    );

    cmp_sweep_checker #(.WIDTH(4), .LAT(2), .ECW(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
        .A_greater_B(flags2[2]), .A_equal_B(flags2[1]), .A_less_B(flags2[0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_a(fa2), .first_err_b(fb2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_a"}, a0, 0);
        check({tag, "_b"}, b0, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_pass"}, pass0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_fa"}, fa0, 0);
        check({tag, "_fb"}, fb0, 0);
    endtask

    // Pulse start on dut0 and count observed busy cycles (bounded).
    task automatic run0(input bit extra_starts, output int cyc);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cyc = 0;
        while (busy0 && cyc < 2000) begin
            cyc++;
            start0 = (extra_starts && (cyc == 10 || cyc == 50)) ? 1'b1 : 1'b0;
            tick();
        end
        start0 = 1'b0;
    endtask

    task automatic check_result0(input string nm, input exp_t e, input int cyc);
        check({nm, "_len"}, cyc, e.len);
        check({nm, "_done"}, done0, 1);
        check({nm, "_busy"}, busy0, 0);
        check({nm, "_pass"}, pass0, (e.err == 0) ? 1 : 0);
        check({nm, "_err"}, err0, e.err);
        check({nm, "_fa"}, fa0, e.fa);
        check({nm, "_fb"}, fb0, e.fb);
        check({nm, "_a"}, a0, e.a_end);
        check({nm, "_b"}, b0, e.b_end);
    endtask

    vec_t tbl[8];

    initial begin
        int cyc;
        string nm;

        tbl[0] = '{mode: 0, fa: 0, fb: 0, mask: 3'b000, extra_starts: 1'b1,
                   e: '{len: 256, err: 0, fa: 0, fb: 0, a_end: 15, b_end: 15}};
        if (STOP)
            tbl[1] = '{mode: 1, fa: 0, fb: 0, mask: 3'b000, extra_starts: 1'b0,
                       e: '{len: 1, err: 1, fa: 0, fb: 0, a_end: 0, b_end: 0}};
        else
            tbl[1] = '{mode: 1, fa: 0, fb: 0, mask: 3'b000, extra_starts: 1'b0,
                       e: '{len: 256, err: 16, fa: 0, fb: 0, a_end: 15, b_end: 15}};
        tbl[2] = '{mode: 0, fa: 0, fb: 0, mask: 3'b000, extra_starts: 1'b0,
                   e: '{len: 256, err: 0, fa: 0, fb: 0, a_end: 15, b_end: 15}};
        if (STOP)
            tbl[3] = '{mode: 2, fa: 3, fb: 1, mask: 3'b100, extra_starts: 1'b0,
                       e: '{len: 50, err: 1, fa: 3, fb: 1, a_end: 3, b_end: 1}};
        else
            tbl[3] = '{mode: 2, fa: 3, fb: 1, mask: 3'b100, extra_starts: 1'b0,
                       e: '{len: 256, err: 1, fa: 3, fb: 1, a_end: 15, b_end: 15}};
        for (int i = 4; i < 8; i++) begin
            tbl[i].mode = (i == 7) ? 1 : 2;
            tbl[i].fa = int'($urandom_range(0, 15));
            tbl[i].fb = int'($urandom_range(0, 15));
            tbl[i].mask = 3'($urandom_range(1, 7));
            tbl[i].extra_starts = 1'b0;
            tbl[i].e = model(tbl[i].mode, tbl[i].fa, tbl[i].fb, tbl[i].mask);
        end

        // Reset, with start held high at the same time.
        start0 = 1'b1;
        repeat (3) tick();
        start0 = 1'b0;
        check_zero0("rst0");
        check("rst2_busy", busy2, 0);
        check("rst2_err", err2, 0);
        check("rst2_a", a2, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy0, 0);

        // Table of sweeps on the LAT=0 instance.
        for (int i = 0; i < 8; i++) begin
            cur_mode = tbl[i].mode;
            cur_fa = tbl[i].fa;
            cur_fb = tbl[i].fb;
            cur_mask = tbl[i].mask;
            run0(tbl[i].extra_starts, cyc);
            nm = $sformatf("vec%0d", i);
            check_result0(nm, tbl[i].e, cyc);
            repeat (5) tick();
            check({nm, "_hold_done"}, done0, 1);
            check({nm, "_hold_err"}, err0, tbl[i].e.err);
            check({nm, "_hold_a"}, a0, tbl[i].e.a_end);
        end

        // Pipelined comparator against LAT=0 must report errors.
        cur_mode = 3;
        run0(1'b0, cyc);
        check("pipe_lat0_errpos", (err0 > 0) ? 1 : 0, 1);
        check("pipe_lat0_pass", pass0, 0);

        // Reset at busy cycle 100, then a clean sweep three cycles later.
        cur_mode = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c < 100 && busy0; c++) tick();
        check("mid_busy_before", busy0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero0("midrst");
        repeat (3) tick();
        run0(1'b0, cyc);
        check_result0("after_rst", tbl[2].e, cyc);

        // LAT=2 instance fed by a two-stage registered comparator.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 3000) begin
            cyc++;
            tick();
        end
        check("lat2_len", cyc, 768);
        check("lat2_done", done2, 1);
        check("lat2_pass", pass2, 1);
        check("lat2_err", err2, 0);
        check("lat2_a", a2, 15);
        check("lat2_b", b2, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Synthesizable driver and checker for the three-output magnitude comparator (A_greater_B / A_equal_B / A_less_B).
- Sweeps every (A,B) pair exhaustively, drives each pair into the comparator, samples the three flags a fixed latency later, and checks them against an internal reference.
- Reports error count, first failing vector, and pass/done; used as an on-board self-test in place of a simulation-only fixture.

Parameters:
- WIDTH, 8, operand width of A and B.
- LAT, 0, cycles between a pair appearing on A/B and flag sampling (0 = combinational comparator, sampled in the same cycle A/B are presented).
- ECW, 16, width of the error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE
- A  out  WIDTH  operand A driven to comparator (registered)
- B  out  WIDTH  operand B driven to comparator (registered)
- A_greater_B  in  1  comparator flag
- A_equal_B  in  1  comparator flag
- A_less_B  in  1  comparator flag
- busy  out  1  high in APPLY state
- done  out  1  high in DONE state
- pass  out  1  done && err_count==0
- err_count  out  ECW  mismatching vectors, saturating at all-ones
- first_err_a  out  WIDTH  A of the first mismatch (0 if none)
- first_err_b  out  WIDTH  B of the first mismatch (0 if none)

Behaviour:
- Reset: state IDLE; A, B, err_count, first_err_a and first_err_b = 0; busy, done and pass = 0. Reset mid-sweep aborts immediately with no partial result kept.
- FSM IDLE -> APPLY on start. APPLY -> DONE after the last vector is sampled. DONE -> APPLY on start. start is ignored in APPLY.
- Starting a sweep: A and B load 0 and wait counter wcnt loads 0; err_count and first_err_* clear in the same edge.
- APPLY timing:
  - The pair is held for LAT+1 cycles.
  - Flags are sampled in the cycle where wcnt==LAT.
  - In that cycle, the pair advances at the edge: B increments. On B wrap (all-ones -> 0), A increments.
  - Total sweep length is exactly 2^(2*WIDTH)*(LAT+1) cycles in APPLY.
- Expected flags: gt = A>B, eq = A==B, lt = A<B, unsigned, computed from the registered A and B.
- Mismatch: any of the three flags differs from expected. This includes illegal combinations such as 000, 110 and 111.
- On mismatch:
  - err_count increments, saturating.
  - If err_count was 0, first_err_a and first_err_b capture the current A and B.
- Last vector is A=B=all-ones. After it is sampled, the next state is DONE, and A and B hold all-ones (no wrap).
- DONE: done=1, busy=0; all results are held stable until start or rst.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro CMP_STOP_ON_ERR_EN.
- Defined: on the first mismatch, the FSM goes straight to DONE at that edge. A and B hold the failing pair (no advance), err_count=1, pass=0.
- Undefined: the full sweep always runs and errors accumulate.

Decomposition:
- Package cmp_pkg holds:
  - state encoding localparams ST_IDLE, ST_APPLY, ST_DONE
  - default WIDTH, LAT and ECW constants
  - a function returning the 3-bit expected flag vector {gt,eq,lt}
- One sub-module, cmp_ref_model: purely combinational reference comparator, WIDTH-parameterized, instantiated inside the checker. It is reusable by other benches.

Test Plan:
- WIDTH=4, LAT=0, correct combinational comparator, start pulse -> busy for exactly 256 cycles, then done=1, pass=1, err_count=0, A=B=4'hF.
- WIDTH=4, LAT=0, comparator with A_equal_B stuck at 0 -> err_count=16, first_err_a=0, first_err_b=0, pass=0.
- WIDTH=4, LAT=2, comparator with 2-stage registered outputs -> 768 busy cycles, pass=1. Same design with LAT=0 -> err_count>0.
- Reset asserted at cycle 100 of a sweep -> next cycle IDLE, all outputs 0. A start pulse 3 cycles later gives a full clean sweep, pass=1.
- start pulses at cycles 10 and 50 during a sweep -> no effect, total length unchanged. start in DONE -> new sweep, err_count cleared.
- CMP_STOP_ON_ERR_EN defined, WIDTH=4, A_greater_B forced 0 when A=3,B=1 -> done asserts on the 50th vector, i.e. at busy cycle 50 (index 3*16+1=49); A=3, B=1, err_count=1, first_err_a=3, first_err_b=1.
